// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin arbiter in front of a single, non-pipelined
// FP adder datapath. One operation is in flight at a time. Each result is
// captured after the datapath latency (shortened when the datapath flags
// special operands) and returned tagged with the requester index.
module fp_add_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ALU_LATENCY    = 3,
    parameter int BYPASS_LATENCY = 1,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    dp_start,
    output logic [31:0]             dp_a,
    output logic [31:0]             dp_b,
    input  logic                    dp_bypass,
    input  logic [31:0]             dp_result,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy,
    output logic [15:0]             ops_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // WAIT counts down from latency-1; the capture happens in the cycle the
    // counter reads zero, so the result is taken exactly latency cycles after
    // the dp_start cycle.
    localparam logic [3:0] ALU_LOAD    = 4'(ALU_LATENCY - 1);
    localparam logic [3:0] BYPASS_LOAD = 4'(BYPASS_LATENCY - 1);

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [3:0]      lat_q, lat_d;
    logic [31:0]     dp_a_q, dp_a_d;
    logic [31:0]     dp_b_q, dp_b_d;
    logic [31:0]     data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [15:0]     ops_q, ops_d;

    logic [31:0]     a_arr [NUM_REQ];
    logic [31:0]     b_arr [NUM_REQ];
    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [NUM_REQ-1:0] grant_vec;

    // Split the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*32 +: 32];
        assign b_arr[gi] = req_b[gi*32 +: 32];
    end

    // Round-robin search starting at rr_q; only grants in IDLE and out of reset.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        if (state_q == S_IDLE && reset_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    // Next-state logic for the issue / wait / respond sequence.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lat_d   = lat_q;
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        data_d  = data_q;
        id_d    = id_q;
        ops_d   = ops_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    dp_a_d  = a_arr[grant_idx];
                    dp_b_d  = b_arr[grant_idx];
                    id_d    = grant_idx;
                    // The winner drops to lowest priority for the next round.
                    if (int'(grant_idx) == NUM_REQ - 1) rr_d = '0;
                    else                                rr_d = grant_idx + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                lat_d   = dp_bypass ? BYPASS_LOAD : ALU_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    data_d  = dp_result;
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: begin
                if (resp_ready) begin
                    ops_d   = ops_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            lat_q   <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lat_q   <= lat_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ops_q   <= ops_d;
        end
    end

    assign req_ready  = grant_vec;
    assign dp_start   = (state_q == S_EXEC) && reset_n;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != S_IDLE);
    assign ops_done   = ops_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: directed + randomized checks of fp_add_scheduler
// against a transaction-level round-robin/latency model and a datapath stub.
module tb_fp_add_scheduler;

    localparam int NUM = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM-1:0]    req_valid;
    logic [NUM-1:0]    req_ready;
    logic [NUM*32-1:0] req_a, req_b;
    logic              dp_start;
    logic [31:0]       dp_a, dp_b;
    logic              dp_bypass;
    logic [31:0]       dp_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [1:0]        resp_id;
    logic              busy;
    logic [15:0]       ops_done;

    logic [31:0] op_a [NUM];
    logic [31:0] op_b [NUM];

    int          checks   = 0;
    int          failures = 0;
    int          exp_rr   = 0;
    logic [15:0] exp_ops  = 16'd0;

    fp_add_scheduler #(.NUM_REQ(NUM), .ALU_LATENCY(3), .BYPASS_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
        .dp_bypass(dp_bypass), .dp_result(dp_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NUM; gi++) begin : g_pack
        assign req_a[gi*32 +: 32] = op_a[gi];
        assign req_b[gi*32 +: 32] = op_b[gi];
    end

    // ---- datapath stub: result valid only in its one correct cycle ----
    function automatic bit is_special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:0] == 31'd0);
    endfunction

    function automatic logic [31:0] dp_func(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b + 32'h00001357;
    endfunction

    function automatic int op_latency(input logic [31:0] a, input logic [31:0] b);
        return (is_special(a) || is_special(b)) ? 1 : 3;
    endfunction

    int          cyc = 0;
    int          valid_cyc = -100;
    logic [31:0] dp_val = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_start) begin
            valid_cyc <= cyc + op_latency(dp_a, dp_b);
            dp_val    <= dp_func(dp_a, dp_b);
        end
    end

    assign dp_result = (cyc == valid_cyc) ? dp_val : (32'hBAD00000 ^ 32'(cyc));
    assign dp_bypass = dp_start ? (is_special(dp_a) || is_special(dp_b)) : cyc[0];

    // ---- helpers ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'h00000000;
        if (r == 1) return 32'h7F800000;
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    task automatic new_ops(input int i);
        op_a[i] = rnd_op();
        op_b[i] = rnd_op();
    endtask

    // One complete transaction from an IDLE cycle through the response handshake.
    task automatic run_txn(input logic [NUM-1:0] mask, input bit keep, input int bp);
        int          g;
        int          lat;
        logic [31:0] ea, eb, ed;
        g = -1;
        req_valid = mask;
        #1;
        for (int k = 0; k < NUM; k++) begin
            int idx;
            idx = (exp_rr + k) % NUM;
            if (g < 0 && mask[idx]) g = idx;
        end
        chk("grant", 32'(req_ready), 32'(1 << g));
        chk("busy_idle", 32'(busy), 32'd0);
        ea  = op_a[g];
        eb  = op_b[g];
        ed  = dp_func(ea, eb);
        lat = op_latency(ea, eb);
        exp_rr = (g + 1) % NUM;
        tick();                                   // EXEC cycle
        new_ops(g);
        if (!keep) req_valid = '0;
        #1;
        chk("dp_start", 32'(dp_start), 32'd1);
        chk("dp_a", dp_a, ea);
        chk("dp_b", dp_b, eb);
        chk("busy_exec", 32'(busy), 32'd1);
        chk("ready_exec", 32'(req_ready), 32'd0);
        for (int c = 0; c < lat; c++) begin       // waiting for the datapath
            tick();
            #1;
            chk("dp_start_wait", 32'(dp_start), 32'd0);
            chk("resp_early", 32'(resp_valid), 32'd0);
            chk("ready_wait", 32'(req_ready), 32'd0);
        end
        tick();                                   // first response cycle
        if (bp > 0) resp_ready = 1'b0;
        #1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_data", resp_data, ed);
        chk("resp_id", 32'(resp_id), 32'(g));
        for (int c = 0; c < bp; c++) begin
            tick();
            #1;
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", resp_data, ed);
            chk("bp_id", 32'(resp_id), 32'(g));
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_start", 32'(dp_start), 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("ops_pre", 32'(ops_done), 32'(exp_ops));
        tick();                                   // back in IDLE
        exp_ops = exp_ops + 16'd1;
        #1;
        chk("resp_clear", 32'(resp_valid), 32'd0);
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
        chk("busy_after", 32'(busy), 32'd0);
        $display("txn id=%0d a=%h b=%h lat=%0d bp=%0d data=%h ops=%0d", g, ea, eb, lat, bp, resp_data, ops_done);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dp_a"}, dp_a, 32'd0);
        chk({tag, "_dp_b"}, dp_b, 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ops"}, 32'(ops_done), 32'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        tick();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(dp_start), 32'd0);
        tick();
        #1;
        check_reset_state("rst");
        reset_n   = 1'b1;
        req_valid = '0;
        exp_rr    = 0;
        exp_ops   = 16'd0;
        tick();
    endtask

    // ---- directed sequence ----
    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM; i++) new_ops(i);
        tick();
        do_reset();

        // Basic normal-latency operation on requester 2.
        op_a[2] = 32'h3F800000;
        op_b[2] = 32'h40000000;
        run_txn(4'b0100, 1'b0, 0);

        // Special-operand (bypass) operation on requester 0.
        op_a[0] = 32'h00000000;
        op_b[0] = 32'h41200000;
        run_txn(4'b0001, 1'b0, 0);

        // All requesters continuously valid after reset: 0,1,2,3,0.
        do_reset();
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 1'b1, 0);
        req_valid = '0;

        // Backpressure on the response for ten cycles.
        run_txn(4'b1000, 1'b0, 10);

        // A competing request dropped before it is granted leaves no trace.
        run_txn(4'b0110, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Randomized masks, operands and backpressure.
        for (int n = 0; n < 24; n++)
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        req_valid = '0;

        // Reset while waiting on the datapath, with rr pointer left non-zero.
        op_a[2] = 32'h3F800000;
        op_b[2] = 32'h3F800000;
        req_valid = 4'b0100;
        tick();                                   // accept edge passed: EXEC
        req_valid = '0;
        tick();                                   // WAIT
        tick();                                   // WAIT
        reset_n   = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        #1;
        check_reset_state("midrst");
        chk("midrst_ready2", 32'(req_ready), 32'd0);
        chk("midrst_start", 32'(dp_start), 32'd0);
        reset_n   = 1'b1;
        req_valid = '0;
        exp_rr    = 0;
        exp_ops   = 16'd0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            chk("no_stale_resp", 32'(resp_valid), 32'd0);
        end
        run_txn(4'b1010, 1'b0, 0);

        // ops_done wrap: preload near the top, then two operations.
        tick();
        force dut.ops_q = 16'hFFFE;
        #1;
        release dut.ops_q;
        #1;
        exp_ops = 16'hFFFE;
        chk("preload", 32'(ops_done), 32'h0000FFFE);
        tick();
        run_txn(4'b0001, 1'b0, 0);
        run_txn(4'b0001, 1'b0, 0);
        chk("wrap_zero", 32'(ops_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
